// File: rtl/noc_tg_pkg.sv
// Shared types and constants for the NoC traffic generator endpoint.
package noc_tg_pkg;

  typedef enum logic [1:0] {IDLE, SEND, FINISHED} tg_state_t;
  typedef enum logic {PAT_RANDOM, PAT_NEIGHBOUR} tg_pattern_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Flit layout: dest in the top AddressWidth bits, src just below the payload MSB
  function automatic int dest_msb(input int total_width);
    return total_width - 1;
  endfunction

  function automatic int src_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/noc_tg_lfsr16.sv
// 16-bit Galois LFSR; reset loads the seed, step advances one position.
// state_nxt is the combinational successor so the caller can look one step ahead.
module noc_tg_lfsr16
  import noc_tg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state,
  output logic [15:0] state_nxt
);

  always_comb begin
    state_nxt = {1'b0, state[15:1]};
    if (state[0]) state_nxt = state_nxt ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (!rst)      state <= seed;
    else if (step) state <= state_nxt;
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Synthetic PE endpoint: injects addressed, sequenced flits (registered, 1 flit/cycle,
// held stable under backpressure) and always sinks delivered flits, with saturating counters.
module noc_traffic_gen
  import noc_tg_pkg::*;
#(
  parameter int    address      = 0,
  parameter int    numPE        = 4,
  parameter int    AddressWidth = $clog2(numPE),
  parameter int    DataWidth    = 32,
  parameter int    TotalWidth   = DataWidth + AddressWidth,
  parameter int    PktLimit     = 100,
  parameter string Pattern      = "RANDOM"
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  input  logic [TotalWidth-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic                  done,
  output logic [31:0]           o_sent_cnt,
  output logic [31:0]           o_recv_cnt,
  output logic [31:0]           o_err_cnt
);

  localparam int DEST_MSB = dest_msb(TotalWidth);
  localparam int SRC_MSB  = src_msb(DataWidth);
  localparam int SEQ_W    = DataWidth - AddressWidth;
  localparam tg_pattern_t PAT = (Pattern == "NEIGHBOUR") ? PAT_NEIGHBOUR : PAT_RANDOM;
  localparam logic [AddressWidth-1:0] MY_ADDR   = AddressWidth'(address);
  localparam logic [AddressWidth-1:0] NEXT_ADDR = MY_ADDR + AddressWidth'(1);

  tg_state_t          state;
  logic [SEQ_W-1:0]   seq_q;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_nxt;
  logic               inj_hs;
  logic               rx_hs;
  logic               last_pkt;
  logic               rx_unused;

  assign inj_hs    = o_data_valid && i_data_ready;
  assign rx_hs     = i_data_valid && o_data_ready;
  assign last_pkt  = ({1'b0, o_sent_cnt} + 33'd1) == 33'(PktLimit);
  assign rx_unused = ^i_data[DEST_MSB-AddressWidth:0];

  noc_tg_lfsr16 u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed      (LFSR_SEED ^ 16'(address)),
    .step      (inj_hs),
    .state     (lfsr),
    .state_nxt (lfsr_nxt)
  );

  // Self-addressed destinations are remapped to the neighbour
  function automatic logic [AddressWidth-1:0] pick_dest(input logic [15:0] l);
    logic [AddressWidth-1:0] d;
    d = l[AddressWidth-1:0];
    if (PAT == PAT_NEIGHBOUR || d == MY_ADDR) d = NEXT_ADDR;
    return d;
  endfunction

  function automatic logic [TotalWidth-1:0] make_flit(input logic [AddressWidth-1:0] dst,
                                                      input logic [SEQ_W-1:0] seq);
    logic [TotalWidth-1:0] f;
    f = '0;
    f[DEST_MSB -: AddressWidth] = dst;
    f[SRC_MSB -: AddressWidth]  = MY_ADDR;
    f[SEQ_W-1:0]                = seq;
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_data_ready <= 1'b0;
      o_sent_cnt   <= '0;
      seq_q        <= '0;
    end else begin
      o_data_ready <= 1'b1;
      case (state)
        IDLE: state <= (PktLimit > 0 && !done) ? SEND : FINISHED;
        SEND: begin
          if (!o_data_valid) begin
            if (done) state <= FINISHED;
            else begin
              o_data       <= make_flit(pick_dest(lfsr), seq_q);
              o_data_valid <= 1'b1;
            end
          end else if (i_data_ready) begin
            o_sent_cnt <= sat_inc(o_sent_cnt);
            seq_q      <= seq_q + SEQ_W'(1);
            if (last_pkt || done) begin
              o_data_valid <= 1'b0;
              state        <= FINISHED;
            end else begin
              // Next flit uses the post-step LFSR so injection stays back-to-back
              o_data <= make_flit(pick_dest(lfsr_nxt), seq_q + SEQ_W'(1));
            end
          end
        end
        default: o_data_valid <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_recv_cnt <= '0;
      o_err_cnt  <= '0;
    end else if (rx_hs) begin
      o_recv_cnt <= sat_inc(o_recv_cnt);
      if (i_data[DEST_MSB -: AddressWidth] != MY_ADDR) o_err_cnt <= sat_inc(o_err_cnt);
    end
  end

endmodule

// File: doc/noc_traffic_gen.md
Name: noc_traffic_gen

Overview:
- Synthetic processing-element endpoint that attaches to one HNoC PE port.
- Injects addressed packets toward the NoC using valid/ready, and sinks packets delivered by the NoC.
- Keeps sent, received and error counters for throughput and correctness runs.
- Sits directly upstream of the HNoC ingress port and downstream of its egress port. Runs on the PE-side clock.

Parameters:
- address, 0, this endpoint's PE address; placed in the source field of every packet.
- numPE, 4, number of PEs on the NoC; must be a power of two, at least 2.
- AddressWidth, $clog2(numPE), width of the destination and source fields.
- DataWidth, 32, payload width.
- TotalWidth, DataWidth+AddressWidth, flit width.
- PktLimit, 100, packets to inject before stopping.
- Pattern, "RANDOM", "RANDOM" or "NEIGHBOUR".

Ports:
- clk  in  1  endpoint clock.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- o_data  out  TotalWidth  injected flit: [TotalWidth-1 -: AddressWidth] = dest, [DataWidth-1 -: AddressWidth] = src, remaining low bits = sequence number.
- o_data_valid  out  1  injected flit valid.
- i_data_ready  in  1  NoC accepts the injected flit.
- i_data  in  TotalWidth  delivered flit.
- i_data_valid  in  1  delivered flit valid.
- o_data_ready  out  1  endpoint accepts the delivered flit.
- done  in  1  global stop; blocks new injections.
- o_sent_cnt  out  32  flits accepted by the NoC.
- o_recv_cnt  out  32  flits received.
- o_err_cnt  out  32  received flits whose dest field is not equal to address.

Behaviour:
- Reset (rst==0 at posedge):
  - o_data_valid=0, o_data=0, o_data_ready=0, all counters=0.
  - LFSR=16'hACE1 ^ address; sequence counter=0; state=IDLE.
- Transfer occurs on any posedge with valid&&ready, on either side.
- FSM states:
  - IDLE: first cycle after reset release. Go to SEND if PktLimit>0 and done==0, otherwise go to FINISHED.
  - SEND:
    - o_data_valid=1.
    - o_data is held stable until i_data_ready, so backpressure of any length is tolerated with no change to o_data.
    - On a handshake: o_sent_cnt+1, sequence+1, LFSR steps once.
    - If o_sent_cnt+1==PktLimit or done==1, go to FINISHED with valid=0 on the next cycle.
    - Otherwise the next flit is presented on the next cycle; valid stays high, giving back-to-back injection at 1 flit/cycle.
  - FINISHED: valid=0 permanently until reset.
- done rules:
  - done asserted while a flit is pending does not withdraw it; the flit completes and then the FSM goes to FINISHED.
  - done in IDLE goes straight to FINISHED.
- Destination:
  - RANDOM: dest = LFSR[AddressWidth-1:0]; if that equals address, use (address+1) mod numPE.
  - NEIGHBOUR: dest = (address+1) mod numPE.
  - Self-addressed flits are never injected.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, stepped only on injection handshakes. The sequence is therefore deterministic per address.
- Sequence field:
  - Width DataWidth-AddressWidth; wraps modulo 2^width without flagging.
  - Flit n carries sequence n-1.
- Receive side:
  - o_data_ready=1 in every cycle after reset release, including FINISHED.
  - Each accepted flit: o_recv_cnt+1, and o_err_cnt+1 if dest != address.
  - Injection and reception are independent and may happen in the same cycle.
- Counters saturate at 32'hFFFFFFFF.
- Reset mid-operation: the pending flit is dropped, all state returns to reset values, and injection restarts from sequence 0 with the seed LFSR.

Decomposition:
- Shared package noc_tg_pkg holds:
  - field offset constants (DEST_MSB, SRC_MSB);
  - pattern encoding constants;
  - the LFSR seed and tap constants;
  - the FSM state typedef (IDLE/SEND/FINISHED).
- One sub-module, noc_tg_lfsr16: 16-bit Galois LFSR with seed load and step enable.
- Counters and FSM stay in the top level.

Test Plan:
- Reset and default params (address=0, numPE=4):
  - During rst=0, all outputs are 0.
  - First cycle after release: valid=0, ready=1.
  - Second cycle: valid=1, src=0, seq=0.
- NEIGHBOUR pattern, address=3, PktLimit=4, ready held 1:
  - Exactly 4 back-to-back flits, each with dest=0, src=3, seq=0,1,2,3.
  - Then valid=0 and o_sent_cnt=4.
- Backpressure, RANDOM pattern:
  - Drop ready for 7 cycles with valid=1: o_data stays constant and o_sent_cnt does not change.
  - Release ready: one handshake, and the next flit has seq+1.
  - Over 100 flits, no dest equals address.
- Receive check, address=2:
  - Drive 5 flits with dest=2 and 2 flits with dest=1: o_recv_cnt=7, o_err_cnt=2.
  - Same stimulus while injecting: both counters are still correct.
- done mid-stream, PktLimit=100:
  - Assert done with a flit pending and ready=0.
  - When ready rises, the flit completes; then valid=0 forever and o_sent_cnt equals the count so far.
- Mid-run reset:
  - Apply rst=0 for 1 cycle after 10 flits: counters clear.
  - The re-run reproduces the identical dest sequence as the first run.
